// File: rtl/reg_if_pkg.sv
// Shared types and constants for the register-interface arbiter.
//   ADDR_W / DATA_W : downstream register bus widths
//   state_t         : arbiter FSM encoding
//   req_t           : one buffered master request
package reg_if_pkg;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA_DEF = 16'hDEAD;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/reg_if_arbiter_if.sv
// Bundle of the arbiter's request, response and downstream register bus.
//   slave  : arbiter view (takes requests, drives reg_if_* downstream)
//   master : environment view (issues requests, models the register file)
interface reg_if_arbiter_if
    import reg_if_pkg::*;
#(
    parameter int unsigned N = 2
);

    logic                  enable;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_we;
    logic [N*ADDR_W-1:0]   req_addr;
    logic [N*DATA_W-1:0]   req_wdata;
    logic [N-1:0]          req_busy;
    logic [N-1:0]          req_drop;
    logic [DATA_W-1:0]     resp_rdata;
    logic [N-1:0]          resp_ready;
    logic [N-1:0]          resp_err;
    logic [ADDR_W-1:0]     reg_if_addr;
    logic [DATA_W-1:0]     reg_if_wdata;
    logic                  reg_if_valid;
    logic                  reg_if_we;
    logic [DATA_W-1:0]     reg_if_rdata;
    logic                  reg_if_ready;

    modport slave (
        input  enable, req_valid, req_we, req_addr, req_wdata,
        input  reg_if_rdata, reg_if_ready,
        output req_busy, req_drop, resp_rdata, resp_ready, resp_err,
        output reg_if_addr, reg_if_wdata, reg_if_valid, reg_if_we
    );

    modport master (
        output enable, req_valid, req_we, req_addr, req_wdata,
        output reg_if_rdata, reg_if_ready,
        input  req_busy, req_drop, resp_rdata, resp_ready, resp_err,
        input  reg_if_addr, reg_if_wdata, reg_if_valid, reg_if_we
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending index after i_last_grant, mod N.
//   i_pending    : per-master pending flags
//   i_last_grant : index of the most recently granted master
//   o_grant_c    : one-hot grant, all zero when nothing is pending
module rr_arbiter #(
    parameter int unsigned N   = 2,
    parameter int unsigned LGW = 1
) (
    input  logic [N-1:0]   i_pending,
    input  logic [LGW-1:0] i_last_grant,
    output logic [N-1:0]   o_grant_c
);

    logic [LGW-1:0] w_idx;
    logic           w_found;

    // Walk the N positions starting just after the last grant; first hit wins.
    always_comb begin
        o_grant_c = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 1; k <= int'(N); k++) begin
            w_idx = LGW'((int'(i_last_grant) + k) % int'(N));
            if (!w_found && i_pending[w_idx]) begin
                o_grant_c[w_idx] = 1'b1;
                w_found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_if_arbiter.sv
// Shares one internal register interface between N register masters.
// One request slot per master, round-robin grant, downstream request held
// until ready or timeout, per-master completion/error pulses.
//   clk_25m, rst_n : clock, async active-low reset
//   bus            : request/response/downstream bundle (slave modport)
module reg_if_arbiter
    import reg_if_pkg::*;
#(
    parameter int unsigned       N            = 2,
    parameter int unsigned       TIMEOUT_CYC  = 64,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
    input  logic              clk_25m,
    input  logic              rst_n,
    reg_if_arbiter_if.slave   bus
);

    localparam int unsigned LGW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t              r_state;
    logic [N-1:0]        r_slot_vld;
    req_t                r_slot [N];
    logic [LGW-1:0]      r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [N-1:0]        r_req_drop;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic [N-1:0]        r_resp_ready;
    logic [N-1:0]        r_resp_err;
    logic [ADDR_W-1:0]   r_reg_addr;
    logic [DATA_W-1:0]   r_reg_wdata;
    logic                r_reg_valid;
    logic                r_reg_we;

    req_t                w_req [N];
    logic [N-1:0]        w_grant;
    logic [LGW-1:0]      w_win;
    logic                w_timeout;

    // Unpack the flattened per-master request buses.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_req[i].we    = bus.req_we[i];
            w_req[i].addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
            w_req[i].wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        end
    end

    rr_arbiter #(
        .N   (N),
        .LGW (LGW)
    ) u_rr_arbiter (
        .i_pending    (r_slot_vld),
        .i_last_grant (r_last_grant),
        .o_grant_c    (w_grant)
    );

    // One-hot grant to index.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_grant[i]) begin
                w_win = LGW'(i);
            end
        end
    end

    assign w_timeout = (r_cnt == CNT_LAST);

    // Slot capture, FSM, timeout counter and all registered outputs.
    // The current grant's slot stays occupied until completion, so a new
    // request on the in-flight port is dropped by the same "slot full" test.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_slot_vld   <= '0;
            for (int i = 0; i < int'(N); i++) begin
                r_slot[i] <= '0;
            end
            r_last_grant <= LGW'(N - 1);
            r_cnt        <= '0;
            r_req_drop   <= '0;
            r_resp_rdata <= '0;
            r_resp_ready <= '0;
            r_resp_err   <= '0;
            r_reg_addr   <= '0;
            r_reg_wdata  <= '0;
            r_reg_valid  <= 1'b0;
            r_reg_we     <= 1'b0;
        end else if (!bus.enable) begin
            // Synchronous flush: in-flight access abandoned without a response.
            r_state      <= IDLE;
            r_slot_vld   <= '0;
            for (int i = 0; i < int'(N); i++) begin
                r_slot[i] <= '0;
            end
            r_last_grant <= LGW'(N - 1);
            r_cnt        <= '0;
            r_req_drop   <= '0;
            r_resp_rdata <= '0;
            r_resp_ready <= '0;
            r_resp_err   <= '0;
            r_reg_addr   <= '0;
            r_reg_wdata  <= '0;
            r_reg_valid  <= 1'b0;
            r_reg_we     <= 1'b0;
        end else begin
            r_req_drop   <= '0;
            r_resp_ready <= '0;
            r_resp_err   <= '0;

            for (int i = 0; i < int'(N); i++) begin
                if (bus.req_valid[i]) begin
                    if (r_slot_vld[i]) begin
                        r_req_drop[i] <= 1'b1;
                    end else begin
                        r_slot_vld[i] <= 1'b1;
                        r_slot[i]     <= w_req[i];
                    end
                end
            end

            case (r_state)
                IDLE: begin
                    if (|r_slot_vld) begin
                        r_state      <= ISSUE;
                        r_reg_valid  <= 1'b1;
                        r_reg_we     <= r_slot[w_win].we;
                        r_reg_addr   <= r_slot[w_win].addr;
                        r_reg_wdata  <= r_slot[w_win].we ? r_slot[w_win].wdata : '0;
                        r_last_grant <= w_win;
                        r_cnt        <= '0;
                    end
                end
                ISSUE: begin
                    // Ready takes priority over a coincident timeout.
                    if (bus.reg_if_ready || w_timeout) begin
                        r_state                    <= IDLE;
                        r_reg_valid                <= 1'b0;
                        r_reg_we                   <= 1'b0;
                        r_slot_vld[r_last_grant]   <= 1'b0;
                        r_resp_ready[r_last_grant] <= 1'b1;
                        r_resp_err[r_last_grant]   <= !bus.reg_if_ready;
                        if (r_reg_we) begin
                            r_resp_rdata <= '0;
                        end else if (bus.reg_if_ready) begin
                            r_resp_rdata <= bus.reg_if_rdata;
                        end else begin
                            r_resp_rdata <= TIMEOUT_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_busy     = r_slot_vld;
    assign bus.req_drop     = r_req_drop;
    assign bus.resp_rdata   = r_resp_rdata;
    assign bus.resp_ready   = r_resp_ready;
    assign bus.resp_err     = r_resp_err;
    assign bus.reg_if_addr  = r_reg_addr;
    assign bus.reg_if_wdata = r_reg_wdata;
    assign bus.reg_if_valid = r_reg_valid;
    assign bus.reg_if_we    = r_reg_we;

endmodule
